// File: rtl/fc_pkg.sv
// Shared state encoding, default sizes and row type for the FC buffer writer.
package fc_pkg;

    localparam int unsigned FC_DATA_W = 8;
    localparam int unsigned FC_LANES  = 128;
    localparam int unsigned FC_PTR_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IF_WR,
        S_W_WR,
        S_START,
        S_WAIT
    } state_t;

    typedef logic [FC_LANES*FC_DATA_W-1:0] row_t;

endpackage

// File: rtl/fc_row_packer.sv
// Assembles one weight-buffer row lane by lane; the completed row (final byte merged in)
// is registered on emit while the working row clears for the next output node.
module fc_row_packer
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W = FC_DATA_W,
    parameter int unsigned LANES  = FC_LANES,
    parameter int unsigned IDX_W  = FC_PTR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_clear,
    input  logic                    i_wr,
    input  logic                    i_emit,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [DATA_W-1:0]       i_data,
    output logic [LANES*DATA_W-1:0] o_row
);

    logic [LANES*DATA_W-1:0] r_row;
    logic [LANES*DATA_W-1:0] r_out;
    logic [LANES*DATA_W-1:0] w_merged;

    always_comb begin
        w_merged = r_row;
        for (int k = 0; k < LANES; k++) begin
            if (i_wr && (i_idx == IDX_W'(k))) begin
                w_merged[k*DATA_W +: DATA_W] = i_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_row <= '0;
            r_out <= '0;
        end else if (i_clear) begin
            r_row <= '0;
        end else if (i_emit) begin
            r_row <= '0;
            r_out <= w_merged;
        end else if (i_wr) begin
            r_row <= w_merged;
        end
    end

    assign o_row = r_out;

endmodule

// File: rtl/fc_buf_writer.sv
// FC ifmap/weight buffer write side: config latch, byte stream to buffers, start/done handshake.
// Optional stream-length checking on s_last_i is enabled by defining FC_LEN_CHECK_EN.
module fc_buf_writer
    import fc_pkg::*;
#(
    parameter int unsigned DATA_W = FC_DATA_W,
    parameter int unsigned LANES  = FC_LANES,
    parameter int unsigned PTR_W  = FC_PTR_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_valid_i,
    output logic                    cfg_ready_o,
    input  logic [PTR_W-1:0]        in_node_num_i,
    input  logic [PTR_W-1:0]        out_node_num_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    input  logic [DATA_W-1:0]       s_data_i,
    input  logic                    s_last_i,
    output logic                    ifmap_wren_o,
    output logic [PTR_W-1:0]        ifmap_wrptr_o,
    output logic [DATA_W-1:0]       ifmap_wdata_o,
    output logic                    wbuf_wren_o,
    output logic [PTR_W-1:0]        wbuf_wrptr_o,
    output logic [LANES*DATA_W-1:0] wbuf_wdata_o,
    output logic                    start_o,
    output logic [PTR_W-1:0]        in_node_num_o,
    output logic [PTR_W-1:0]        out_node_num_o,
    input  logic                    fc_done_i,
    output logic                    busy_o,
    output logic                    err_o
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [PTR_W-1:0] r_idx;
    logic [PTR_W-1:0] w_idx_nxt;
    logic [PTR_W-1:0] r_row;
    logic [PTR_W-1:0] w_row_nxt;
    logic [PTR_W-1:0] r_n;
    logic [PTR_W-1:0] r_m;
    logic             r_cfg_ready;
    logic             r_s_ready;
    logic             r_if_wren;
    logic [PTR_W-1:0] r_if_ptr;
    logic [DATA_W-1:0] r_if_data;
    logic             r_wb_wren;
    logic [PTR_W-1:0] r_wb_ptr;
    logic             r_start;

    logic w_cfg_acc;
    logic w_cfg_ok;
    logic w_if_acc;
    logic w_w_acc;
    logic w_idx_last;
    logic w_row_last;
    logic w_row_end;

    // Readies are registered decodes of the next state so they read 0 while held in reset.
    assign w_cfg_acc  = cfg_valid_i && r_cfg_ready;
    assign w_cfg_ok   = w_cfg_acc && (in_node_num_i != '0) && (out_node_num_i != '0);
    assign w_if_acc   = s_valid_i && r_s_ready && (r_state == S_IF_WR);
    assign w_w_acc    = s_valid_i && r_s_ready && (r_state == S_W_WR);
    assign w_idx_last = (r_idx == r_n - PTR_W'(1));
    assign w_row_last = (r_row == r_m - PTR_W'(1));
    assign w_row_end  = w_w_acc && w_idx_last;

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_row_nxt   = r_row;
        unique case (r_state)
            S_IDLE: begin
                if (w_cfg_ok) begin
                    w_state_nxt = S_IF_WR;
                    w_idx_nxt   = '0;
                    w_row_nxt   = '0;
                end
            end
            S_IF_WR: begin
                if (w_if_acc) begin
                    if (w_idx_last) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_W_WR;
                    end else begin
                        w_idx_nxt = r_idx + PTR_W'(1);
                    end
                end
            end
            S_W_WR: begin
                if (w_w_acc) begin
                    if (w_idx_last) begin
                        w_idx_nxt = '0;
                        if (w_row_last) begin
                            w_state_nxt = S_START;
                        end else begin
                            w_row_nxt = r_row + PTR_W'(1);
                        end
                    end else begin
                        w_idx_nxt = r_idx + PTR_W'(1);
                    end
                end
            end
            S_START: w_state_nxt = S_WAIT;
            S_WAIT: begin
                if (fc_done_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_row       <= '0;
            r_n         <= '0;
            r_m         <= '0;
            r_cfg_ready <= 1'b0;
            r_s_ready   <= 1'b0;
            r_if_wren   <= 1'b0;
            r_if_ptr    <= '0;
            r_if_data   <= '0;
            r_wb_wren   <= 1'b0;
            r_wb_ptr    <= '0;
            r_start     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_row       <= w_row_nxt;
            r_cfg_ready <= (w_state_nxt == S_IDLE);
            r_s_ready   <= (w_state_nxt == S_IF_WR) || (w_state_nxt == S_W_WR);
            if (w_cfg_ok) begin
                r_n <= in_node_num_i;
                r_m <= out_node_num_i;
            end
            r_if_wren <= w_if_acc;
            if (w_if_acc) begin
                r_if_ptr  <= r_idx;
                r_if_data <= s_data_i;
            end
            r_wb_wren <= w_row_end;
            if (w_row_end) begin
                r_wb_ptr <= r_row;
            end
            r_start <= (r_state == S_START);
        end
    end

    fc_row_packer #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .IDX_W  (PTR_W)
    ) u_row_packer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_cfg_acc),
        .i_wr    (w_w_acc),
        .i_emit  (w_row_end),
        .i_idx   (r_idx),
        .i_data  (s_data_i),
        .o_row   (wbuf_wdata_o)
    );

`ifdef FC_LEN_CHECK_EN
    logic r_err;
    logic w_last_exp;

    // Marker is due on the final ifmap byte and on the final byte of the last weight row.
    assign w_last_exp = (r_state == S_IF_WR) ? w_idx_last : (w_idx_last && w_row_last);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_cfg_ok) begin
            r_err <= 1'b0;
        end else if ((w_if_acc || w_w_acc) && (s_last_i != w_last_exp)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;
`else
    logic w_unused_last;
    assign w_unused_last = s_last_i;
    assign err_o         = 1'b0;
`endif

    assign cfg_ready_o    = r_cfg_ready;
    assign s_ready_o      = r_s_ready;
    assign ifmap_wren_o   = r_if_wren;
    assign ifmap_wrptr_o  = r_if_ptr;
    assign ifmap_wdata_o  = r_if_data;
    assign wbuf_wren_o    = r_wb_wren;
    assign wbuf_wrptr_o   = r_wb_ptr;
    assign start_o        = r_start;
    assign in_node_num_o  = r_n;
    assign out_node_num_o = r_m;
    assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_fc_buf_writer.sv
// Randomized self-checking bench for fc_buf_writer against a queue-based layer model.
module tb_fc_buf_writer;

    localparam int DW = 8;
    localparam int LN = 128;
    localparam int PW = 7;
    localparam int RW = LN * DW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid_i = 1'b0;
    logic          cfg_ready_o;
    logic [PW-1:0] in_node_num_i = '0;
    logic [PW-1:0] out_node_num_i = '0;
    logic          s_valid_i = 1'b0;
    logic          s_ready_o;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          ifmap_wren_o;
    logic [PW-1:0] ifmap_wrptr_o;
    logic [DW-1:0] ifmap_wdata_o;
    logic          wbuf_wren_o;
    logic [PW-1:0] wbuf_wrptr_o;
    logic [RW-1:0] wbuf_wdata_o;
    logic          start_o;
    logic [PW-1:0] in_node_num_o;
    logic [PW-1:0] out_node_num_o;
    logic          fc_done_i = 1'b0;
    logic          busy_o;
    logic          err_o;

    fc_buf_writer u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_valid_i    (cfg_valid_i),
        .cfg_ready_o    (cfg_ready_o),
        .in_node_num_i  (in_node_num_i),
        .out_node_num_i (out_node_num_i),
        .s_valid_i      (s_valid_i),
        .s_ready_o      (s_ready_o),
        .s_data_i       (s_data_i),
        .s_last_i       (s_last_i),
        .ifmap_wren_o   (ifmap_wren_o),
        .ifmap_wrptr_o  (ifmap_wrptr_o),
        .ifmap_wdata_o  (ifmap_wdata_o),
        .wbuf_wren_o    (wbuf_wren_o),
        .wbuf_wrptr_o   (wbuf_wrptr_o),
        .wbuf_wdata_o   (wbuf_wdata_o),
        .start_o        (start_o),
        .in_node_num_o  (in_node_num_o),
        .out_node_num_o (out_node_num_o),
        .fc_done_i      (fc_done_i),
        .busy_o         (busy_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int exp_start_cyc = 0;
    bit start_seen = 1'b0;
    bit last_acc = 1'b0;

    logic [DW-1:0] stim[$];
    int            exp_if_addr[$];
    logic [DW-1:0] exp_if_data[$];
    int            exp_wb_row[$];
    logic [RW-1:0] exp_wb_data[$];

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock: note whether a byte was handed over, then check any outputs that fired.
    task automatic tick();
        logic [RW-1:0] want;
        last_acc = rst_n && s_valid_i && s_ready_o;
        @(posedge clk);
        #1;
        cyc++;
        if (ifmap_wren_o) begin
            if (exp_if_addr.size() == 0) begin
                check_eq("if_extra", ifmap_wren_o, 1'b0);
            end else begin
                check_eq("if_addr", ifmap_wrptr_o, exp_if_addr.pop_front());
                check_eq("if_data", ifmap_wdata_o, exp_if_data.pop_front());
            end
        end
        if (wbuf_wren_o) begin
            if (exp_wb_row.size() == 0) begin
                check_eq("wb_extra", wbuf_wren_o, 1'b0);
            end else begin
                check_eq("wb_row", wbuf_wrptr_o, exp_wb_row.pop_front());
                want = exp_wb_data.pop_front();
                for (int c = 0; c < RW / 128; c++) begin
                    check_eq("wb_data", wbuf_wdata_o[c*128 +: 128], want[c*128 +: 128]);
                end
            end
        end
        if (start_o) begin
            check_eq("start_cyc", cyc, exp_start_cyc);
            start_seen    = 1'b1;
            exp_start_cyc = 0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq(tag, {ifmap_wren_o, ifmap_wrptr_o, ifmap_wdata_o, wbuf_wren_o, wbuf_wrptr_o,
                       start_o, in_node_num_o, out_node_num_o, busy_o, err_o, cfg_ready_o,
                       s_ready_o}, '0);
        for (int c = 0; c < RW / 128; c++) begin
            check_eq(tag, wbuf_wdata_o[c*128 +: 128], '0);
        end
    endtask

    task automatic send_cfg(input int n, input int m);
        int t;
        cfg_valid_i    = 1'b1;
        in_node_num_i  = PW'(n);
        out_node_num_i = PW'(m);
        t = 0;
        while (!cfg_ready_o && t < 20) begin
            tick();
            t++;
        end
        check_eq("cfg_ready", cfg_ready_o, 1'b1);
        tick();
        cfg_valid_i = 1'b0;
    endtask

    task automatic fill_seq(input int count, input int first);
        stim.delete();
        for (int k = 0; k < count; k++) stim.push_back(DW'(first + k));
    endtask

    task automatic fill_rand(input int count);
        stim.delete();
        for (int k = 0; k < count; k++) stim.push_back(DW'($urandom));
    endtask

    // mode: 0 back-to-back, 1 valid every other cycle, 2 random valid plus stray fc_done.
    task automatic run_layer(input int n, input int m, input int mode, input bit swap_last,
                             input int hold, input int abort_at);
        int total, i, guard, last_edge, t;
        bit v, lst, exp_err;
        logic [RW-1:0] rw;
        total = n + n * m;
`ifdef FC_LEN_CHECK_EN
        exp_err = swap_last;
`else
        exp_err = 1'b0;
`endif
        for (int k = 0; k < n; k++) begin
            exp_if_addr.push_back(k);
            exp_if_data.push_back(stim[k]);
        end
        for (int r = 0; r < m; r++) begin
            rw = '0;
            for (int k = 0; k < n; k++) rw[k*DW +: DW] = stim[n + r * n + k];
            exp_wb_row.push_back(r);
            exp_wb_data.push_back(rw);
        end
        send_cfg(n, m);
        check_eq("lat_n", in_node_num_o, n);
        check_eq("lat_m", out_node_num_o, m);
        check_eq("busy_run", busy_o, 1'b1);
        check_eq("err_clr", err_o, 1'b0);
        i = 0;
        guard = 0;
        last_edge = 0;
        while (i < total && guard < total * 8 + 64) begin
            if (abort_at >= 0 && i == abort_at) break;
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            lst = (i == total - 1) || (swap_last ? (i == n - 2) : (i == n - 1));
            s_valid_i = v;
            s_data_i  = v ? stim[i] : DW'($urandom);
            s_last_i  = v && lst;
            fc_done_i = (mode == 2) && ($urandom_range(0, 3) == 0);
            tick();
            guard++;
            if (last_acc) begin
                if (i == total - 1) last_edge = cyc;
                i++;
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
        fc_done_i = 1'b0;
        if (abort_at >= 0) begin
            exp_if_addr.delete();
            exp_if_data.delete();
            exp_wb_row.delete();
            exp_wb_data.delete();
            rst_n = 1'b0;
            tick();
            check_all_zero("abort_zero");
            tick();
            tick();
            rst_n = 1'b1;
            repeat (6) tick();
            check_eq("abort_idle", busy_o, 1'b0);
            return;
        end
        check_eq("bytes_taken", i, total);
        exp_start_cyc = last_edge + 1;
        start_seen = 1'b0;
        for (t = 0; t < 8 && !start_seen; t++) tick();
        check_eq("start_seen", start_seen, 1'b1);
        tick();
        check_eq("start_1cyc", start_o, 1'b0);
        check_eq("if_left", exp_if_addr.size(), 0);
        check_eq("wb_left", exp_wb_row.size(), 0);
        for (t = 0; t < hold; t++) tick();
        check_eq("wait_cfg_rdy", cfg_ready_o, 1'b0);
        check_eq("wait_s_rdy", s_ready_o, 1'b0);
        check_eq("wait_busy", busy_o, 1'b1);
        check_eq("err_val", err_o, exp_err);
        fc_done_i = 1'b1;
        tick();
        fc_done_i = 1'b0;
        check_eq("done_cfg_rdy", cfg_ready_o, 1'b1);
        check_eq("done_busy", busy_o, 1'b0);
    endtask

    initial begin
        int n, m;
        rst_n = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check_eq("idle_cfg_rdy", cfg_ready_o, 1'b1);

        fill_seq(12, 1);
        run_layer(4, 2, 0, 1'b0, 50, -1);
        fill_seq(12, 1);
        run_layer(4, 2, 1, 1'b0, 3, -1);

        send_cfg(0, 3);
        repeat (5) tick();
        check_eq("drop_busy", busy_o, 1'b0);
        check_eq("drop_cfg_rdy", cfg_ready_o, 1'b1);
        stim.delete();
        stim.push_back(8'd7);
        stim.push_back(8'd9);
        run_layer(1, 1, 0, 1'b0, 2, -1);

        fill_seq(12, 1);
        run_layer(4, 2, 0, 1'b0, 0, 7);
        fill_seq(12, 21);
        run_layer(4, 2, 0, 1'b0, 1, -1);

`ifdef FC_LEN_CHECK_EN
        fill_seq(4, 1);
        run_layer(2, 1, 0, 1'b1, 4, -1);
`endif

        fill_rand(127 * 3);
        run_layer(127, 2, 0, 1'b0, 1, -1);
        fill_rand(2 * 127 + 2);
        run_layer(2, 127, 2, 1'b0, 1, -1);
        for (int l = 0; l < 6; l++) begin
            n = $urandom_range(1, 24);
            m = $urandom_range(1, 6);
            fill_rand(n + n * m);
            run_layer(n, m, 2, 1'b0, $urandom_range(0, 5), -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
